// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode
//
// Instruction fetch/decode sequencer sitting on the consumer side of the
// instruction ROM. It drives the program counter onto the ROM address,
// captures the returned word, splits it into opcode/register/immediate fields
// and hands each decoded operation to the datapath over a valid/ready
// handshake. Execution stops on the all-zero HALT word or on an illegal
// opcode (1010..1111).
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   start     begin execution at address 0 (only honoured in IDLE or HALT)
//   address   ROM address = program counter
//   code      ROM data, combinational from address
//   op_valid  decoded operation presented to the datapath
//   op_ready  datapath accepts the operation
//   opcode    registered opcode field
//   rx, ry    destination / source register indices
//   imm       16-bit immediate (LOAD)
//   load_en   opcode 0001
//   mov_en    opcode 0010
//   alu_en    opcode 0011..1001
//   alu_op    opcode - 3 while alu_en is set, 0 otherwise
//   busy      FETCH, DECODE or ISSUE
//   halted    HALT state
//   illegal   sticky flag: HALT was entered on an illegal opcode

module instr_fetch_decode #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CODE_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] address,
  input  logic [CODE_W-1:0] code,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [3:0]        opcode,
  output logic [2:0]        rx,
  output logic [2:0]        ry,
  output logic [15:0]       imm,
  output logic              load_en,
  output logic              mov_en,
  output logic              alu_en,
  output logic [2:0]        alu_op,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StHalt
  } state_e;

  localparam logic [3:0] OpHalt     = 4'b0000;
  localparam logic [3:0] OpLoad     = 4'b0001;
  localparam logic [3:0] OpMov      = 4'b0010;
  localparam logic [3:0] OpAluFirst = 4'b0011;
  localparam logic [3:0] OpIllegal  = 4'b1010;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CODE_W-1:0] ir_q, ir_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [2:0]        rx_q, rx_d;
  logic [2:0]        ry_q, ry_d;
  logic [15:0]       imm_q, imm_d;
  logic              load_en_q, load_en_d;
  logic              mov_en_q, mov_en_d;
  logic              alu_en_q, alu_en_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic              illegal_q, illegal_d;

  // Field split of the instruction register. imm overlaps ry on purpose:
  // LOAD uses the full 16 bits, MOV/ALU only the top three.
  logic [3:0]  dec_opcode;
  logic [2:0]  dec_rx;
  logic [2:0]  dec_ry;
  logic [15:0] dec_imm;
  logic [3:0]  dec_alu_sel;
  logic        dec_is_halt;
  logic        dec_is_illegal;
  logic        handshake;

  assign dec_opcode     = ir_q[CODE_W-1 -: 4];
  assign dec_rx         = ir_q[CODE_W-5 -: 3];
  assign dec_ry         = ir_q[CODE_W-8 -: 3];
  assign dec_imm        = ir_q[15:0];
  assign dec_alu_sel    = dec_opcode - OpAluFirst;
  assign dec_is_halt    = (dec_opcode == OpHalt);
  assign dec_is_illegal = (dec_opcode >= OpIllegal);

  assign handshake = (state_q == StIssue) && op_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        state_d = StDecode;
      end
      StDecode: begin
        if (dec_is_halt || dec_is_illegal) begin
          state_d = StHalt;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (op_ready) state_d = StFetch;
      end
      StHalt: begin
        if (start) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    op_valid = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      StIdle:   ;
      StFetch:  busy = 1'b1;
      StDecode: busy = 1'b1;
      StIssue: begin
        busy     = 1'b1;
        op_valid = 1'b1;
      end
      StHalt:   halted = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: program counter, instruction register, decoded fields
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    opcode_d  = opcode_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    imm_d     = imm_q;
    load_en_d = load_en_q;
    mov_en_d  = mov_en_q;
    alu_en_d  = alu_en_q;
    alu_op_d  = alu_op_q;
    illegal_d = illegal_q;

    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_d      = '0;
          illegal_d = 1'b0;
        end
      end
      StFetch: begin
        ir_d = code;
      end
      StDecode: begin
        if (dec_is_illegal) begin
          illegal_d = 1'b1;
        end else if (!dec_is_halt) begin
          // Fields are captured only for issued operations so they stay put
          // for the whole ISSUE phase, however long op_ready is held low.
          opcode_d  = dec_opcode;
          rx_d      = dec_rx;
          ry_d      = dec_ry;
          imm_d     = dec_imm;
          load_en_d = (dec_opcode == OpLoad);
          mov_en_d  = (dec_opcode == OpMov);
          alu_en_d  = (dec_opcode >= OpAluFirst);
          alu_op_d  = (dec_opcode >= OpAluFirst) ? dec_alu_sel[2:0] : 3'd0;
        end
      end
      StIssue: begin
        if (handshake) begin
          // pc wraps naturally at 2^ADDR_W.
          pc_d      = pc_q + ADDR_W'(1);
          // Enables are only meaningful alongside op_valid.
          load_en_d = 1'b0;
          mov_en_d  = 1'b0;
          alu_en_d  = 1'b0;
          alu_op_d  = 3'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      ir_q      <= '0;
      opcode_q  <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      imm_q     <= '0;
      load_en_q <= 1'b0;
      mov_en_q  <= 1'b0;
      alu_en_q  <= 1'b0;
      alu_op_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      opcode_q  <= opcode_d;
      rx_q      <= rx_d;
      ry_q      <= ry_d;
      imm_q     <= imm_d;
      load_en_q <= load_en_d;
      mov_en_q  <= mov_en_d;
      alu_en_q  <= alu_en_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
    end
  end

  assign address = pc_q;
  assign opcode  = opcode_q;
  assign rx      = rx_q;
  assign ry      = ry_q;
  assign imm     = imm_q;
  assign load_en = load_en_q;
  assign mov_en  = mov_en_q;
  assign alu_en  = alu_en_q;
  assign alu_op  = alu_op_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  address;
  logic [22:0] code;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  opcode;
  logic [2:0]  rx, ry;
  logic [15:0] imm;
  logic        load_en, mov_en, alu_en;
  logic [2:0]  alu_op;
  logic        busy, halted, illegal;

  logic [22:0] rom     [32];
  logic [22:0] std_rom [32];
  assign code = rom[address];

  always #5 clk = ~clk;

  instr_fetch_decode #(.ADDR_W(5), .CODE_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .address(address), .code(code),
    .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode), .rx(rx), .ry(ry),
    .imm(imm), .load_en(load_en), .mov_en(mov_en), .alu_en(alu_en), .alu_op(alu_op),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  // Expected operation as seen by the datapath, derived from the opcode table.
  typedef struct packed {
    logic [3:0]  opc;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] imm;
    logic        ld;
    logic        mv;
    logic        al;
    logic [2:0]  aop;
  } op_t;

  op_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  hs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] mk(input logic [3:0] op, input logic [2:0] r,
                                     input logic [15:0] im);
    return {op, r, im};
  endfunction

  function automatic op_t expect_of(input logic [22:0] w);
    op_t e;
    int  o;
    o     = int'(w[22:19]);
    e.opc = w[22:19];
    e.rx  = w[18:16];
    e.ry  = w[15:13];
    e.imm = w[15:0];
    e.ld  = (o == 1);
    e.mv  = (o == 2);
    e.al  = (o >= 3 && o <= 9);
    e.aop = e.al ? 3'(o - 3) : 3'd0;
    return e;
  endfunction

  // Walk the program as the specification describes it: issue every legal
  // word in address order, stop on 0000 or on an opcode >= 1010.
  task automatic build_exp(input int max_n, output int stop_addr, output bit ill);
    int          pc;
    logic [22:0] w;
    pc = 0;
    ill = 1'b0;
    stop_addr = -1;
    exp_q.delete();
    while (exp_q.size() < max_n) begin
      w = rom[pc];
      if (int'(w[22:19]) == 0) begin
        stop_addr = pc;
        return;
      end
      if (int'(w[22:19]) >= 10) begin
        ill = 1'b1;
        stop_addr = pc;
        return;
      end
      exp_q.push_back(expect_of(w));
      pc = (pc + 1) % 32;
    end
  endtask

  // Scoreboard: every accepted operation must match the next expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (op_valid) chk("onehot_en", $countones({load_en, mov_en, alu_en}), 1);
      else          chk("idle_en", {load_en, mov_en, alu_en}, 3'b000);
      if (op_valid && op_ready) begin
        op_t e;
        hs_cnt++;
        chk("issue_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("opcode", opcode, e.opc);
          chk("rx", rx, e.rx);
          chk("imm", imm, e.imm);
          chk("enables", {load_en, mov_en, alu_en}, {e.ld, e.mv, e.al});
          if (!e.ld) chk("ry", ry, e.ry);
          chk("alu_op", alu_op, e.aop);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start the loaded program and run until halted, optionally with random
  // backpressure and random start pulses while busy.
  task automatic run_prog(input bit rnd_ready, input bit rnd_start, output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!halted && cyc < 3000) begin
      op_ready = rnd_ready ? (($urandom % 4) != 0) : 1'b1;
      start    = (rnd_start && busy) ? 1'($urandom % 2) : 1'b0;
      tick();
      cyc++;
    end
    start    = 1'b0;
    op_ready = 1'b1;
    chk("run_timeout", cyc < 3000, 1);
  endtask

  task automatic load_std();
    for (int a = 0; a < 32; a++) rom[a] = 23'd0;
    rom[0] = mk(4'd1, 3'd0, 16'h000C);
    for (int a = 1; a < 18; a++)
      rom[a] = mk(4'($urandom_range(1, 9)), 3'($urandom), 16'($urandom));
    rom[8]  = mk(4'd2, 3'd0, {3'd4, 13'($urandom)});
    rom[11] = mk(4'd3, 3'd3, {3'd0, 13'($urandom)});
    rom[16] = mk(4'd8, 3'd2, {3'd5, 13'($urandom)});
    for (int a = 0; a < 32; a++) std_rom[a] = rom[a];
  endtask

  initial begin
    int cyc, sa, h0, len, prev;
    bit ill, wrap;

    rst_n = 1'b0;
    start = 1'b0;
    op_ready = 1'b1;
    load_std();

    // Reset state
    #12;
    chk("rst_address", address, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_fields", {opcode, rx, ry, imm}, 0);
    chk("rst_enables", {load_en, mov_en, alu_en, alu_op}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_no_start", busy, 0);

    // Standard program, op_ready held high
    build_exp(64, sa, ill);
    h0 = hs_cnt;
    run_prog(1'b0, 1'b0, cyc);
    chk("std_cycles", cyc, 56);
    chk("std_halted", halted, 1);
    chk("std_illegal", illegal, 0);
    chk("std_address", address, 18);
    chk("std_count", hs_cnt - h0, 18);
    chk("std_left", exp_q.size(), 0);

    // Backpressure on addr 11 (ADD R3 R0)
    build_exp(64, sa, ill);
    h0 = hs_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (address != 5'd11 && cyc < 200) begin tick(); cyc++; end
    op_ready = 1'b0;
    while (!op_valid && cyc < 200) begin tick(); cyc++; end
    chk("bp_timeout", cyc < 200, 1);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) op_ready = 1'b1;
      chk("bp_valid", op_valid, 1);
      chk("bp_fields", {rx, ry, alu_op, alu_en}, {3'd3, 3'd0, 3'd0, 1'b1});
      chk("bp_address", address, 11);
      tick();
    end
    chk("bp_after_addr", address, 12);
    chk("bp_after_valid", op_valid, 0);
    cyc = 0;
    while (!halted && cyc < 200) begin tick(); cyc++; end
    chk("bp_halted", halted, 1);
    chk("bp_count", hs_cnt - h0, 18);
    chk("bp_left", exp_q.size(), 0);

    // Illegal word at addr 2, then restart
    rom[2] = mk(4'b1011, 3'($urandom), 16'($urandom));
    build_exp(64, sa, ill);
    run_prog(1'b0, 1'b0, cyc);
    chk("ill_flag", illegal, ill);
    chk("ill_halted", halted, 1);
    chk("ill_address", address, sa);
    chk("ill_left", exp_q.size(), 0);
    build_exp(64, sa, ill);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_illegal", illegal, 0);
    chk("restart_address", address, 0);
    chk("restart_busy", {busy, halted}, 2'b10);
    cyc = 0;
    while (!halted && cyc < 200) begin tick(); cyc++; end
    chk("ill2_flag", illegal, 1);
    chk("ill2_left", exp_q.size(), 0);

    // Start pulses while busy must be ignored
    for (int a = 0; a < 32; a++) rom[a] = std_rom[a];
    build_exp(64, sa, ill);
    h0 = hs_cnt;
    run_prog(1'b0, 1'b1, cyc);
    chk("sp_cycles", cyc, 56);
    chk("sp_address", address, 18);
    chk("sp_count", hs_cnt - h0, 18);
    chk("sp_left", exp_q.size(), 0);

    // Random programs, random backpressure, random start pulses
    for (int it = 0; it < 5; it++) begin
      len = $urandom_range(1, 28);
      for (int a = 0; a < 32; a++)
        rom[a] = mk(4'($urandom_range(1, 9)), 3'($urandom), 16'($urandom));
      rom[len] = (it % 2 == 1) ? mk(4'($urandom_range(10, 15)), 3'($urandom), 16'($urandom))
                               : 23'd0;
      build_exp(64, sa, ill);
      run_prog(1'b1, 1'b1, cyc);
      chk("rnd_halted", halted, 1);
      chk("rnd_illegal", illegal, ill);
      chk("rnd_address", address, sa);
      chk("rnd_left", exp_q.size(), 0);
    end

    // Reset while issuing addr 5
    for (int a = 0; a < 32; a++) rom[a] = std_rom[a];
    build_exp(64, sa, ill);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (address != 5'd5 && cyc < 200) begin tick(); cyc++; end
    op_ready = 1'b0;
    while (!op_valid && cyc < 200) begin tick(); cyc++; end
    chk("mid_timeout", cyc < 200, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", op_valid, 0);
    chk("mid_address", address, 0);
    chk("mid_state", {busy, halted, illegal}, 3'b000);
    chk("mid_enables", {load_en, mov_en, alu_en}, 3'b000);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    op_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("mid_quiet", {op_valid, busy, address}, 0);
    end

    // No HALT word: pc wraps past 31 and issue continues
    for (int a = 0; a < 32; a++) rom[a] = mk(4'd1, 3'($urandom), 16'($urandom));
    build_exp(40, sa, ill);
    h0 = hs_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    wrap = 1'b0;
    while (hs_cnt - h0 < 40 && cyc < 500) begin
      chk("wrap_busy", busy, 1);
      prev = int'(address);
      tick();
      cyc++;
      if (prev == 31 && address == 5'd0) wrap = 1'b1;
    end
    op_ready = 1'b0;
    chk("wrap_seen", wrap, 1);
    chk("wrap_left", exp_q.size(), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
